btb_tagged: RTL and testbench
=============================

BTB_TAGGED -- requirements
Module: btb_tagged

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/target width.
REQ-002 SHALL have parameter ENTRIES, default 32, table depth; power of 2, >= 2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter FETCH_W, default 2, number of prediction lanes.
REQ-004 SHALL have parameter RET_W, default 2, number of update lanes.
REQ-005 SHALL have parameter TAG_W, default 8, stored tag width.
REQ-006 SHALL have parameter IDX_LSB, default 2, lowest PC bit used for indexing.
REQ-007 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port fetch_pc_i  input  FETCH_W x XLEN  PC per fetch lane.
REQ-010 SHALL have port fetch_branch_en_i  input  FETCH_W  lane holds a branch.
REQ-011 SHALL have port predict_en_o  output  FETCH_W  predicted taken.
REQ-012 SHALL have port predict_addr_o  output  FETCH_W x XLEN  predicted next PC.
REQ-013 SHALL have port predict_hit_o  output  FETCH_W  valid tag match in table.
REQ-014 SHALL have port upd_valid_i  input  RET_W  resolved branch update present.
REQ-015 SHALL have port upd_pc_i  input  RET_W x XLEN  PC of resolved branch.
REQ-016 SHALL have port upd_taken_i  input  RET_W  actual direction.
REQ-017 SHALL have port upd_target_i  input  RET_W x XLEN  actual taken target.
REQ-018 SHALL have port flush_i  input  1  invalidate all entries.

Function
REQ-019 SHALL hold per entry: valid (1), tag (TAG_W), target (XLEN), ctr (2-bit saturating).
REQ-020 SHALL compute idx = pc[IDX_LSB +: IDX_W], tag = pc[IDX_LSB+IDX_W +: TAG_W] for fetch and update PCs.
REQ-021 SHALL compute prediction combinationally from registered state, zero-cycle latency; no bypass of same-cycle updates.
REQ-022 SHALL per lane, when fetch_branch_en_i=1: hit = valid & tag match; en = hit & ctr>=2; addr = en ? target : pc+4 (mod 2^XLEN).
REQ-023 SHALL drive hit=0, en=0, addr=0 on any lane with fetch_branch_en_i=0.
REQ-024 SHALL on update hit: taken -> ctr saturating increment (max 3), target <= upd_target_i; not taken -> ctr saturating decrement (min 0), target unchanged.
REQ-025 SHALL on update miss with taken=1: allocate/replace entry: valid=1, tag written, target=upd_target_i, ctr=2.
REQ-026 SHALL on update miss with taken=0: leave entry unchanged.
REQ-027 SHALL apply update lanes in order 0..RET_W-1 within one cycle; later lanes see earlier lanes' results (same index accumulates, e.g. two not-taken from ctr=2 yields 0).
REQ-028 SHALL on flush_i=1: clear every valid bit at next edge, ignore all updates that cycle; tag/target/ctr unchanged.
REQ-029 SHALL register all state at the same rising edge; no multi-cycle operations, no stall outputs.

Reset
REQ-030 SHALL on reset=1, immediately (asynchronously): valid=0, tag=0, target=0, ctr=1 for all entries.
REQ-031 SHALL during and after reset predict miss on all lanes (addr = pc+4 for branch lanes).
REQ-032 SHALL ignore updates and flush while reset=1; first update takes effect at first rising edge after deassertion.

Verification (ENTRIES=32, IDX_LSB=2, TAG_W=8)
REQ-033 SHALL cover: after reset, fetch 0x100 branch_en=1 -> hit=0, en=0, addr=0x104.
REQ-034 SHALL cover: update lane0 pc=0x100 taken target=0x200; next cycle fetch 0x100 -> hit=1, en=1, addr=0x200; lane1 fetch 0x180 (same idx 0, tag 3 vs 2) -> hit=0, addr=0x184.
REQ-035 SHALL cover: with 0x100 at ctr=2, two not-taken updates for 0x100 on lanes 0 and 1 same cycle -> ctr=0, fetch gives en=0, addr=0x104; one further taken -> ctr=1, still en=0, target 0x200 retained.
REQ-036 SHALL cover: flush_i=1 concurrent with taken update pc=0x140 -> next cycle fetch 0x100 and 0x140 both hit=0.
REQ-037 SHALL cover: reset asserted between clock edges with 0x100 trained -> predict_hit_o drops to 0 before next edge; fetch 0x100 addr=0x104.
REQ-038 SHALL cover: fetch 0xFFFFFFFC branch_en=1 on miss -> addr=0x00000000 (wrap).

Source files
------------

// File: rtl/btb_tagged.sv
// Tagged branch target buffer: multi-lane combinational lookup, in-order multi-lane update,
// 2-bit saturating direction counters, flush, and asynchronous reset.
module btb_tagged #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 32,
    parameter int FETCH_W = 2,
    parameter int RET_W   = 2,
    parameter int TAG_W   = 8,
    parameter int IDX_LSB = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [FETCH_W-1:0][XLEN-1:0]   fetch_pc_i,
    input  logic [FETCH_W-1:0]             fetch_branch_en_i,
    output logic [FETCH_W-1:0]             predict_en_o,
    output logic [FETCH_W-1:0][XLEN-1:0]   predict_addr_o,
    output logic [FETCH_W-1:0]             predict_hit_o,
    input  logic [RET_W-1:0]               upd_valid_i,
    input  logic [RET_W-1:0][XLEN-1:0]     upd_pc_i,
    input  logic [RET_W-1:0]               upd_taken_i,
    input  logic [RET_W-1:0][XLEN-1:0]     upd_target_i,
    input  logic                           flush_i
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    function automatic idx_t pc_idx(input logic [XLEN-1:0] pc);
        return pc[IDX_LSB +: IDX_W];
    endfunction

    function automatic tag_t pc_tag(input logic [XLEN-1:0] pc);
        return pc[IDX_LSB+IDX_W +: TAG_W];
    endfunction

    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][XLEN-1:0]  target_q, target_d;
    logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;

    idx_t upd_idx [RET_W];
    tag_t upd_tag [RET_W];

    // Only the index and tag fields of an update PC matter.
    logic upd_pc_unused;
    assign upd_pc_unused = ^upd_pc_i;

    for (genvar l = 0; l < RET_W; l++) begin : g_upd_fields
        assign upd_idx[l] = pc_idx(upd_pc_i[l]);
        assign upd_tag[l] = pc_tag(upd_pc_i[l]);
    end

    // Lookup reads registered state only; same-cycle updates are not bypassed.
    always_comb begin
        predict_hit_o  = '0;
        predict_en_o   = '0;
        predict_addr_o = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (fetch_branch_en_i[i]) begin
                predict_hit_o[i] = valid_q[pc_idx(fetch_pc_i[i])] &&
                                   (tag_q[pc_idx(fetch_pc_i[i])] == pc_tag(fetch_pc_i[i]));
                predict_en_o[i]  = predict_hit_o[i] && ctr_q[pc_idx(fetch_pc_i[i])][1];
                predict_addr_o[i] = predict_en_o[i] ? target_q[pc_idx(fetch_pc_i[i])]
                                                    : fetch_pc_i[i] + XLEN'(4);
            end
        end
    end

    // Lanes are applied in order against the accumulated next state, so a later
    // lane hitting the same entry sees what the earlier lanes wrote.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            for (int l = 0; l < RET_W; l++) begin
                if (upd_valid_i[l]) begin
                    if (valid_d[upd_idx[l]] && (tag_d[upd_idx[l]] == upd_tag[l])) begin
                        if (upd_taken_i[l]) begin
                            if (ctr_d[upd_idx[l]] != 2'd3) begin
                                ctr_d[upd_idx[l]] = ctr_d[upd_idx[l]] + 2'd1;
                            end
                            target_d[upd_idx[l]] = upd_target_i[l];
                        end else if (ctr_d[upd_idx[l]] != 2'd0) begin
                            ctr_d[upd_idx[l]] = ctr_d[upd_idx[l]] - 2'd1;
                        end
                    end else if (upd_taken_i[l]) begin
                        valid_d[upd_idx[l]]  = 1'b1;
                        tag_d[upd_idx[l]]    = upd_tag[l];
                        target_d[upd_idx[l]] = upd_target_i[l];
                        ctr_d[upd_idx[l]]    = 2'd2;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {ENTRIES{2'b01}};
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_btb_tagged.sv
// Directed bench for btb_tagged at default parameters: vector table plus
// hand-written reset/flush sequences.
module tb_btb_tagged;
    logic              clk;
    logic              reset;
    logic [1:0][31:0]  fetch_pc_i;
    logic [1:0]        fetch_branch_en_i;
    logic [1:0]        predict_en_o;
    logic [1:0][31:0]  predict_addr_o;
    logic [1:0]        predict_hit_o;
    logic [1:0]        upd_valid_i;
    logic [1:0][31:0]  upd_pc_i;
    logic [1:0]        upd_taken_i;
    logic [1:0][31:0]  upd_target_i;
    logic              flush_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    btb_tagged dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_pc_i        (fetch_pc_i),
        .fetch_branch_en_i (fetch_branch_en_i),
        .predict_en_o      (predict_en_o),
        .predict_addr_o    (predict_addr_o),
        .predict_hit_o     (predict_hit_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .flush_i           (flush_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  uv;
        logic [1:0]  ut;
        logic [31:0] up0, tg0, up1, tg1;
        logic        fl;
        logic [1:0]  fe;
        logic [31:0] fp0, fp1;
        logic [1:0]  eh, ee;
        logic [31:0] ea0, ea1;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mk(input logic [1:0] uv, input logic [1:0] ut,
                                input logic [31:0] up0, input logic [31:0] tg0,
                                input logic [31:0] up1, input logic [31:0] tg1,
                                input logic fl, input logic [1:0] fe,
                                input logic [31:0] fp0, input logic [31:0] fp1,
                                input logic [1:0] eh, input logic [1:0] ee,
                                input logic [31:0] ea0, input logic [31:0] ea1);
        vec_t v;
        v.uv = uv; v.ut = ut; v.up0 = up0; v.tg0 = tg0; v.up1 = up1; v.tg1 = tg1;
        v.fl = fl; v.fe = fe; v.fp0 = fp0; v.fp1 = fp1;
        v.eh = eh; v.ee = ee; v.ea0 = ea0; v.ea1 = ea1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic clear_upd();
        upd_valid_i  = '0;
        upd_taken_i  = '0;
        upd_pc_i     = '0;
        upd_target_i = '0;
        flush_i      = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        @(negedge clk);
        upd_valid_i       = v.uv;
        upd_taken_i       = v.ut;
        upd_pc_i[0]       = v.up0;
        upd_target_i[0]   = v.tg0;
        upd_pc_i[1]       = v.up1;
        upd_target_i[1]   = v.tg1;
        flush_i           = v.fl;
        fetch_branch_en_i = v.fe;
        fetch_pc_i[0]     = v.fp0;
        fetch_pc_i[1]     = v.fp1;
        #1;
        chk($sformatf("v%0d_hit", n),   32'(predict_hit_o), 32'(v.eh));
        chk($sformatf("v%0d_en", n),    32'(predict_en_o),  32'(v.ee));
        chk($sformatf("v%0d_addr0", n), predict_addr_o[0],  v.ea0);
        chk($sformatf("v%0d_addr1", n), predict_addr_o[1],  v.ea1);
    endtask

    initial begin
        // Index/tag for reference: 0x100 -> idx0 tag2, 0x180 -> idx0 tag3,
        // 0x140 -> idx16 tag2, 0x1C0 -> idx16 tag3.
        vt[0]  = mk(2'b00, 2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 2'b11, 32'h100, 32'h180, 2'b00, 2'b00, 32'h104, 32'h184);
        vt[1]  = mk(2'b01, 2'b01, 32'h100, 32'h200, 32'h0,   32'h0,   1'b0, 2'b01, 32'h100, 32'h180, 2'b00, 2'b00, 32'h104, 32'h0);
        vt[2]  = mk(2'b11, 2'b00, 32'h100, 32'h0,   32'h100, 32'h0,   1'b0, 2'b11, 32'h100, 32'h180, 2'b01, 2'b01, 32'h200, 32'h184);
        vt[3]  = mk(2'b01, 2'b01, 32'h100, 32'h200, 32'h0,   32'h0,   1'b0, 2'b01, 32'h100, 32'h0,   2'b01, 2'b00, 32'h104, 32'h0);
        vt[4]  = mk(2'b01, 2'b01, 32'h100, 32'h280, 32'h0,   32'h0,   1'b0, 2'b01, 32'h100, 32'h0,   2'b01, 2'b00, 32'h104, 32'h0);
        vt[5]  = mk(2'b11, 2'b11, 32'h100, 32'h280, 32'h100, 32'h280, 1'b0, 2'b01, 32'h100, 32'h0,   2'b01, 2'b01, 32'h280, 32'h0);
        vt[6]  = mk(2'b01, 2'b00, 32'h100, 32'hDEAD0000, 32'h0, 32'h0, 1'b0, 2'b01, 32'h100, 32'h0,  2'b01, 2'b01, 32'h280, 32'h0);
        vt[7]  = mk(2'b00, 2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 2'b11, 32'h100, 32'h140, 2'b01, 2'b01, 32'h280, 32'h144);
        vt[8]  = mk(2'b11, 2'b01, 32'h140, 32'h500, 32'h140, 32'h0,   1'b0, 2'b11, 32'h140, 32'h100, 2'b10, 2'b10, 32'h144, 32'h280);
        vt[9]  = mk(2'b01, 2'b01, 32'h140, 32'h500, 32'h0,   32'h0,   1'b0, 2'b11, 32'h140, 32'h100, 2'b11, 2'b10, 32'h144, 32'h280);
        vt[10] = mk(2'b11, 2'b11, 32'h140, 32'h600, 32'h180, 32'h600, 1'b1, 2'b11, 32'h140, 32'h100, 2'b11, 2'b11, 32'h500, 32'h280);
        vt[11] = mk(2'b00, 2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 2'b11, 32'h100, 32'h140, 2'b00, 2'b00, 32'h104, 32'h144);
        vt[12] = mk(2'b01, 2'b00, 32'h1C0, 32'h900, 32'h0,   32'h0,   1'b0, 2'b11, 32'h180, 32'hFFFFFFFC, 2'b00, 2'b00, 32'h184, 32'h0);
        vt[13] = mk(2'b00, 2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 2'b11, 32'h1C0, 32'h140, 2'b00, 2'b00, 32'h1C4, 32'h144);

        // Reset phase: predictions must miss while reset is held.
        reset = 1'b0;
        clear_upd();
        fetch_branch_en_i = 2'b01;
        fetch_pc_i        = '0;
        fetch_pc_i[0]     = 32'h100;
        #2 reset = 1'b1;
        upd_valid_i = 2'b01; upd_taken_i = 2'b01;
        upd_pc_i[0] = 32'h100; upd_target_i[0] = 32'h200;
        #1;
        chk("rst_hit",  32'(predict_hit_o), 32'h0);
        chk("rst_addr", predict_addr_o[0],  32'h104);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ignore_upd", 32'(predict_hit_o), 32'h0);
        clear_upd();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, vt[i]);

        // Train 0x100, then assert reset between edges.
        @(negedge clk);
        clear_upd();
        upd_valid_i = 2'b01; upd_taken_i = 2'b01;
        upd_pc_i[0] = 32'h100; upd_target_i[0] = 32'h200;
        fetch_branch_en_i = 2'b11;
        fetch_pc_i[0] = 32'h100; fetch_pc_i[1] = 32'h140;
        @(negedge clk);
        clear_upd();
        #1;
        chk("train_hit",  32'(predict_hit_o), 32'h1);
        chk("train_addr", predict_addr_o[0],  32'h200);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_hit",  32'(predict_hit_o), 32'h0);
        chk("async_rst_en",   32'(predict_en_o),  32'h0);
        chk("async_rst_addr", predict_addr_o[0],  32'h104);
        upd_valid_i = 2'b01; upd_taken_i = 2'b01;
        upd_pc_i[0] = 32'h140; upd_target_i[0] = 32'h700;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_hit",   32'(predict_hit_o), 32'h0);
        chk("post_rst_addr1", predict_addr_o[1],  32'h144);
        @(negedge clk);
        clear_upd();
        #1;
        chk("first_upd_hit",   32'(predict_hit_o), 32'h2);
        chk("first_upd_en",    32'(predict_en_o),  32'h2);
        chk("first_upd_addr1", predict_addr_o[1],  32'h700);
        chk("first_upd_addr0", predict_addr_o[0],  32'h104);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
